// File: rtl/tof_poll_ctrl.sv
// tof_poll_ctrl
// Polls a TOF10120 ranging sensor over UART and sequences its ASCII distance parser.
// Every poll period the command "r6#" goes out through the UART transmitter. The
// controller then forwards exactly one FRAME_LEN-byte response to the parser, checks
// that response bytes 1..3 are ASCII digits, and pulses parser_rst whenever the parser
// may have lost byte alignment (receive timeout or bad frame).
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   en                  polling enable (sampled in IDLE, WAIT and CHECK only)
//   tx_busy             UART transmitter busy
//   tx_start, tx_data   one-cycle send request and the command byte to send
//   rx_data, rx_valid   received UART byte and its one-cycle strobe
//   fwd_data, fwd_valid byte and strobe to the parser (one cycle after rx_valid)
//   parser_rst          one-cycle pulse that re-aligns the parser
//   frame_ok            one-cycle pulse: good frame delivered
//   frame_err           one-cycle pulse: non-digit in frame bytes 1..3
//   timeout_err         one-cycle pulse: frame not complete within TIMEOUT_CYC
//   poll_fail           one-cycle pulse: command retries exhausted
//   err_cnt             saturating count of frame_err and timeout_err events
//   busy                controller is not in IDLE
module tof_poll_ctrl #(
    parameter int POLL_CYC    = 5_000_000,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int FRAME_LEN   = 8,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] fwd_data,
    output logic       fwd_valid,
    output logic       parser_rst,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       poll_fail,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int PW = (POLL_CYC    > 1) ? $clog2(POLL_CYC)    : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (FRAME_LEN   > 1) ? $clog2(FRAME_LEN)   : 1;
    localparam int RW = (MAX_RETRY   > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, SEND, TXW, RECV, CHECK} state_t;

    state_t          state;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   to_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [RW-1:0]   retry;
    logic [1:0]      idx;
    logic            txw_first;
    logic            bad;

    function automatic logic [7:0] cmd_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h72;   // 'r'
            2'd1:    return 8'h36;   // '6'
            default: return 8'h23;   // '#'
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            poll_cnt    <= '0;
            to_cnt      <= '0;
            byte_cnt    <= '0;
            retry       <= '0;
            idx         <= '0;
            txw_first   <= 1'b0;
            bad         <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            fwd_data    <= '0;
            fwd_valid   <= 1'b0;
            parser_rst  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            poll_fail   <= 1'b0;
            err_cnt     <= '0;
            busy        <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            fwd_valid   <= 1'b0;
            parser_rst  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            poll_fail   <= 1'b0;

            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= WAIT;
                        poll_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                WAIT: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (poll_cnt == PW'(POLL_CYC - 1)) begin
                        state <= SEND;
                        idx   <= 2'd0;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        tx_data   <= cmd_byte(idx);
                        txw_first <= 1'b1;
                        state     <= TXW;
                    end
                end

                // The transmitter only raises tx_busy after it has seen tx_start, so
                // the first TXW cycle would still read a stale idle level.
                TXW: begin
                    if (txw_first) begin
                        txw_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (idx != 2'd2) begin
                            idx   <= idx + 2'd1;
                            state <= SEND;
                        end else begin
                            state    <= RECV;
                            byte_cnt <= '0;
                            to_cnt   <= '0;
                            bad      <= 1'b0;
                        end
                    end
                end

                // The timeout counter parks at TIMEOUT_CYC-1, so a byte arriving on the
                // expiry cycle wins and the timeout fires on the next idle cycle.
                RECV: begin
                    if (to_cnt != TW'(TIMEOUT_CYC - 1)) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (rx_valid) begin
                        fwd_valid <= 1'b1;
                        fwd_data  <= rx_data;
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (byte_cnt >= BW'(1) && byte_cnt <= BW'(3) && !is_digit(rx_data)) begin
                            bad <= 1'b1;
                        end
                        if (byte_cnt == BW'(FRAME_LEN - 1)) begin
                            state <= CHECK;
                        end
                    end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        parser_rst  <= 1'b1;
                        err_cnt     <= sat_inc(err_cnt);
                        if (retry < RW'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            idx   <= 2'd0;
                            state <= SEND;
                        end else begin
                            poll_fail <= 1'b1;
                            retry     <= '0;
                            poll_cnt  <= '0;
                            state     <= WAIT;
                        end
                    end
                end

                CHECK: begin
                    if (bad) begin
                        frame_err  <= 1'b1;
                        parser_rst <= 1'b1;
                        err_cnt    <= sat_inc(err_cnt);
                    end else begin
                        frame_ok <= 1'b1;
                        retry    <= '0;
                    end
                    if (en) begin
                        state    <= WAIT;
                        poll_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tof_poll_ctrl.sv
// tb_tof_poll_ctrl
// Bench for tof_poll_ctrl with POLL_CYC=20, TIMEOUT_CYC=50, MAX_RETRY=2 and a UART TX
// stand-in that stays busy for 10 cycles after each tx_start. A transaction-level
// reference model (command byte queue, received-frame queue, elapsed-cycle counts)
// predicts every output each cycle; directed scenarios add hand-computed expectations,
// followed by a randomized stretch of enables, resets, responses and line noise.
module tb_tof_poll_ctrl;

    localparam int POLL = 20;
    localparam int TO   = 50;
    localparam int FL   = 8;
    localparam int MR   = 2;
    localparam int TXB  = 10;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_SEND  = 2;
    localparam int P_ACK   = 3;
    localparam int P_RECV  = 4;
    localparam int P_CHECK = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] fwd_data;
    logic       fwd_valid;
    logic       parser_rst;
    logic       frame_ok;
    logic       frame_err;
    logic       timeout_err;
    logic       poll_fail;
    logic [7:0] err_cnt;
    logic       busy;

    tof_poll_ctrl #(
        .POLL_CYC   (POLL),
        .TIMEOUT_CYC(TO),
        .FRAME_LEN  (FL),
        .MAX_RETRY  (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fwd_data   (fwd_data),
        .fwd_valid  (fwd_valid),
        .parser_rst (parser_rst),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .poll_fail  (poll_fail),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: busy for TXB cycles starting the cycle after tx_start.
    int tx_cnt = 0;
    always @(posedge clk) begin
        if (tx_start)        tx_cnt <= TXB;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0);

    // ---------------- reference model ----------------
    int         cyc = 0;
    int         m_phase = P_IDLE;
    int         waited = 0;
    int         ack_age = 0;
    int         elapsed = 0;
    int         retries = 0;
    int         errs = 0;
    logic [7:0] cmd_q[$];
    logic [7:0] frame_q[$];
    logic       e_tx_start = 0, e_fwd_valid = 0, e_prst = 0, e_ok = 0;
    logic       e_ferr = 0, e_to = 0, e_pf = 0, e_busy = 0;
    logic [7:0] e_tx_data = 0, e_fwd_data = 0;

    function automatic bit digit(input logic [7:0] b);
        return (b >= "0") && (b <= "9");
    endfunction

    function automatic bit frame_good();
        for (int i = 1; i <= 3; i++) if (!digit(frame_q[i])) return 0;
        return 1;
    endfunction

    task automatic load_cmd();
        cmd_q.delete();
        cmd_q.push_back(8'h72);
        cmd_q.push_back(8'h36);
        cmd_q.push_back(8'h23);
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = P_IDLE; waited = 0; ack_age = 0; elapsed = 0; retries = 0; errs = 0;
            cmd_q.delete(); frame_q.delete();
            e_tx_start = 0; e_tx_data = 0; e_fwd_valid = 0; e_fwd_data = 0;
            e_prst = 0; e_ok = 0; e_ferr = 0; e_to = 0; e_pf = 0;
        end else begin
            e_tx_start = 0; e_fwd_valid = 0; e_prst = 0; e_ok = 0;
            e_ferr = 0; e_to = 0; e_pf = 0;
            case (m_phase)
                P_IDLE: if (en) begin m_phase = P_WAIT; waited = 0; end
                P_WAIT: begin
                    if (!en) m_phase = P_IDLE;
                    else begin
                        waited++;
                        if (waited == POLL) begin load_cmd(); m_phase = P_SEND; end
                    end
                end
                P_SEND: begin
                    if (!tx_busy) begin
                        e_tx_start = 1;
                        e_tx_data  = cmd_q.pop_front();
                        ack_age    = 0;
                        m_phase    = P_ACK;
                    end
                end
                P_ACK: begin
                    ack_age++;
                    if (ack_age >= 2 && !tx_busy) begin
                        if (cmd_q.size() != 0) m_phase = P_SEND;
                        else begin m_phase = P_RECV; frame_q.delete(); elapsed = 0; end
                    end
                end
                P_RECV: begin
                    if (rx_valid) begin
                        e_fwd_valid = 1;
                        e_fwd_data  = rx_data;
                        frame_q.push_back(rx_data);
                        if (frame_q.size() == FL) m_phase = P_CHECK;
                    end else if (elapsed >= TO - 1) begin
                        e_to = 1; e_prst = 1;
                        if (errs < 255) errs++;
                        if (retries < MR) begin retries++; load_cmd(); m_phase = P_SEND; end
                        else begin e_pf = 1; retries = 0; waited = 0; m_phase = P_WAIT; end
                    end
                    elapsed++;
                end
                P_CHECK: begin
                    if (frame_good()) begin e_ok = 1; retries = 0; end
                    else begin e_ferr = 1; e_prst = 1; if (errs < 255) errs++; end
                    if (en) begin m_phase = P_WAIT; waited = 0; end
                    else m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
        e_busy = (m_phase != P_IDLE);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step();
    end

    // ---------------- checking ----------------
    int         checks = 0;
    int         errors = 0;
    int         n_tx, n_fwd, n_ok, n_ferr, n_to, n_pf, n_prst;
    int         first_tx_cyc, first_to_cyc;
    logic [7:0] tx_log[$];
    logic [7:0] fwd_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] dut_vec();
        return {tx_start, tx_data, fwd_valid, fwd_data, parser_rst, frame_ok,
                frame_err, timeout_err, poll_fail, err_cnt, busy};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {e_tx_start, e_tx_data, e_fwd_valid, e_fwd_data, e_prst, e_ok,
                e_ferr, e_to, e_pf, errs[7:0], e_busy};
    endfunction

    task automatic clear_obs();
        n_tx = 0; n_fwd = 0; n_ok = 0; n_ferr = 0; n_to = 0; n_pf = 0; n_prst = 0;
        first_tx_cyc = -1; first_to_cyc = -1;
        tx_log.delete(); fwd_log.delete();
    endtask

    // Advance to the next falling edge, compare every output with the model, log events.
    task automatic tick();
        @(negedge clk);
        check($sformatf("outputs@%0d", cyc), 64'(dut_vec()), 64'(exp_vec()));
        if (tx_start) begin
            n_tx++; tx_log.push_back(tx_data);
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
        end
        if (fwd_valid) begin n_fwd++; fwd_log.push_back(fwd_data); end
        if (frame_ok)  n_ok++;
        if (frame_err) n_ferr++;
        if (timeout_err) begin
            n_to++;
            if (first_to_cyc < 0) first_to_cyc = cyc;
        end
        if (poll_fail)  n_pf++;
        if (parser_rst) n_prst++;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; rx_valid = 0;
        repeat (3) tick();
        check("reset_outputs", 64'(dut_vec()), 64'h0);
        rst = 0;
        tick();
        clear_obs();
    endtask

    task automatic wait_phase(input int p, input int budget, input string name);
        int n = 0;
        while (m_phase != p && n < budget) begin tick(); n++; end
        if (m_phase != p) bound_expired(name);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_valid = 1; rx_data = s[i];
            tick();
        end
        rx_valid = 0;
    endtask

    function automatic logic [63:0] fwd_packed();
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++)
            v = {v[55:0], (i < fwd_log.size()) ? fwd_log[i] : 8'h00};
        return v;
    endfunction

    initial begin
        int en_edge, recv_cyc, n;
        bit in_recv, silent;

        // 1: first command timing and byte order
        do_reset();
        en = 1;
        en_edge = cyc + 1;
        n = 0;
        while (n_tx == 0 && n < 60) begin tick(); n++; end
        if (n_tx == 0) bound_expired("first_tx");
        check("first_tx_latency", 64'(first_tx_cyc - en_edge), 64'd21);
        wait_phase(P_RECV, 200, "recv_after_cmd");
        check("cmd_count", 64'(n_tx), 64'd3);
        check("cmd_bytes", {40'h0, tx_log[0], tx_log[1], tx_log[2]}, 64'h723623);

        // 2: good frame
        send_str("L123mm\r\n");
        repeat (4) tick();
        check("good_fwd_count", 64'(n_fwd), 64'd8);
        check("good_fwd_bytes", fwd_packed(), 64'h4C3132336D6D0D0A);
        check("good_frame_ok", 64'(n_ok), 64'd1);
        check("good_frame_err", 64'(n_ferr), 64'd0);
        check("good_err_cnt", 64'(err_cnt), 64'd0);
        check("good_busy_wait", 64'(busy), 64'd1);

        // 3: no response, three timeouts then poll_fail
        clear_obs();
        wait_phase(P_RECV, 200, "recv_for_timeout");
        recv_cyc = cyc;
        n = 0;
        while (n_to == 0 && n < 100) begin tick(); n++; end
        if (n_to == 0) bound_expired("first_timeout");
        check("timeout_latency", 64'(first_to_cyc - recv_cyc), 64'd50);
        n = 0;
        while (n_pf == 0 && n < 400) begin tick(); n++; end
        if (n_pf == 0) bound_expired("poll_fail");
        check("timeout_count", 64'(n_to), 64'd3);
        check("timeout_prst", 64'(n_prst), 64'd3);
        check("timeout_resends", 64'(n_tx), 64'd9);
        check("timeout_err_cnt", 64'(err_cnt), 64'd3);
        tick();
        check("poll_fail_busy", 64'(busy), 64'd1);

        // 4: bad frame
        do_reset();
        en = 1;
        wait_phase(P_RECV, 200, "recv_bad");
        send_str("L1A3mm\r\n");
        repeat (4) tick();
        check("bad_frame_err", 64'(n_ferr), 64'd1);
        check("bad_frame_ok", 64'(n_ok), 64'd0);
        check("bad_prst", 64'(n_prst), 64'd1);
        check("bad_err_cnt", 64'(err_cnt), 64'd1);

        // 5: noise outside RECV, then a byte on the timeout-expiry cycle
        clear_obs();
        rx_valid = 1; rx_data = 8'h55;
        n = 0;
        while (m_phase != P_RECV && n < 300) begin tick(); n++; end
        rx_valid = 0;
        if (m_phase != P_RECV) bound_expired("recv_noise");
        check("noise_no_fwd", 64'(n_fwd), 64'd0);
        repeat (TO - 1) tick();
        rx_valid = 1; rx_data = 8'h4C;
        tick();
        rx_valid = 0;
        check("expiry_fwd_valid", 64'(fwd_valid), 64'd1);
        check("expiry_fwd_data", 64'(fwd_data), 64'h4C);
        check("expiry_no_timeout", 64'(timeout_err), 64'd0);
        tick();
        check("expiry_timeout_next", 64'(timeout_err), 64'd1);

        // 6: reset mid-RECV, then saturate err_cnt
        do_reset();
        en = 1;
        wait_phase(P_RECV, 200, "recv_rst");
        send_str("L12");
        rst = 1;
        tick();
        check("rst_mid_recv", 64'(dut_vec()), 64'h0);
        rst = 0;
        for (int k = 0; k < 300; k++) begin
            wait_phase(P_RECV, 300, "recv_sat");
            send_str("LXYZmm\r\n");
        end
        repeat (3) tick();
        check("err_cnt_saturated", 64'(err_cnt), 64'd255);

        // Randomized stretch
        in_recv = 0; silent = 0;
        for (int k = 0; k < 15000; k++) begin
            if (m_phase == P_RECV && !in_recv) silent = ($urandom_range(0, 3) == 0);
            in_recv = (m_phase == P_RECV);
            if (in_recv && !silent) rx_valid = ($urandom_range(0, 2) == 0);
            else                    rx_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) != 0) rx_data = 8'h30 + 8'($urandom_range(0, 9));
            else                           rx_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) en = ~en;
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 0; rx_valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
